// File: rtl/hrav_pack_fifo_pkg.sv
// Shared helpers for the narrow-to-wide packing FIFO.
// Provides a constant-foldable clog2 and the slice-count width derivation,
// so every module sizes its count ports identically.
package hrav_pack_fifo_pkg;

  // Ceiling log2, usable in parameter and port-width expressions.
  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Width of a slice count that must represent 0..ratio inclusive.
  function automatic int unsigned cnt_width(input int unsigned ratio);
    return clog2_f(ratio) + 1;
  endfunction

endpackage

// File: rtl/hrav_slice_packer.sv
// Slice accumulator for the packing FIFO.
// Ports:
//   clk, reset_n   clock, async active-low reset
//   wr_en          accepted slice write (already qualified against full)
//   din, din_last  slice data; din_last closes the current word
//   commit_c       word completes this cycle
//   word_c         accumulator merged with din, unused upper slices zeroed
//   cnt_c          number of valid slices in word_c (acc_cnt+1)
module hrav_slice_packer
  import hrav_pack_fifo_pkg::*;
#(
  parameter int unsigned DINWIDTH  = 8,
  parameter int unsigned DOUTWIDTH = 256
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic                                         wr_en,
  input  logic [DINWIDTH-1:0]                          din,
  input  logic                                         din_last,
  output logic                                         commit_c,
  output logic [DOUTWIDTH-1:0]                         word_c,
  output logic [cnt_width(DOUTWIDTH/DINWIDTH)-1:0]     cnt_c
);

  localparam int unsigned RATIO = DOUTWIDTH / DINWIDTH;
  localparam int unsigned CNTW  = cnt_width(RATIO);

  logic [CNTW-1:0]      acc_cnt_q, acc_cnt_d;
  logic [DOUTWIDTH-1:0] acc_q, acc_d;

  // Merge din into the slot at acc_cnt; slots above it are forced to zero so
  // stale accumulator contents never leak into a short (din_last) word.
  always_comb begin
    word_c   = '0;
    commit_c = wr_en && (din_last || (acc_cnt_q == CNTW'(RATIO - 1)));
    cnt_c    = acc_cnt_q + CNTW'(1);
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (CNTW'(k) < acc_cnt_q) begin
        word_c[k*DINWIDTH +: DINWIDTH] = acc_q[k*DINWIDTH +: DINWIDTH];
      end else if (CNTW'(k) == acc_cnt_q) begin
        word_c[k*DINWIDTH +: DINWIDTH] = din;
      end
    end
    acc_d     = wr_en ? word_c : acc_q;
    acc_cnt_d = acc_cnt_q;
    if (commit_c) begin
      acc_cnt_d = '0;
    end else if (wr_en) begin
      acc_cnt_d = acc_cnt_q + CNTW'(1);
    end
  end

  // Slice count; reset discards any partial word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_cnt_q <= '0;
    end else begin
      acc_cnt_q <= acc_cnt_d;
    end
  end

  // Accumulator data carries no reset; unwritten slots are masked on merge.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

endmodule

// File: rtl/hrav_pack_fifo.sv
// Narrow-to-wide packing FIFO: packs DOUTWIDTH/DINWIDTH input slices into one
// wide word and buffers up to 2**DEPTH words.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   wr_en, din, din_last  slice write; din_last flushes a partial word
//   full                  registered, storage holds 2**DEPTH words
//   rd_en                 pop one word (ignored while empty)
//   dout, dout_cnt        registered packed word and its valid-slice count
//   empty                 registered, storage holds no words
module hrav_pack_fifo
  import hrav_pack_fifo_pkg::*;
#(
  parameter int unsigned DINWIDTH  = 8,
  parameter int unsigned DOUTWIDTH = 256,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic                                         wr_en,
  input  logic [DINWIDTH-1:0]                          din,
  input  logic                                         din_last,
  output logic                                         full,
  input  logic                                         rd_en,
  output logic [DOUTWIDTH-1:0]                         dout,
  output logic [cnt_width(DOUTWIDTH/DINWIDTH)-1:0]     dout_cnt,
  output logic                                         empty
);

  localparam int unsigned RATIO   = DOUTWIDTH / DINWIDTH;
  localparam int unsigned CNTW    = cnt_width(RATIO);
  localparam int unsigned ENTRIES = 1 << DEPTH;
  localparam int unsigned OCCW    = DEPTH + 1;

  logic                 accept_wr, accept_rd;
  logic                 commit;
  logic [DOUTWIDTH-1:0] commit_word;
  logic [CNTW-1:0]      commit_cnt;

  logic [DOUTWIDTH-1:0] data_mem [ENTRIES];
  logic [CNTW-1:0]      cnt_mem  [ENTRIES];

  logic [DEPTH-1:0]     wr_ptr_q, wr_ptr_d;
  logic [DEPTH-1:0]     rd_ptr_q, rd_ptr_d;
  logic [OCCW-1:0]      occ_q, occ_d;
  logic                 full_q, empty_q;
  logic [DOUTWIDTH-1:0] dout_q;
  logic [CNTW-1:0]      dout_cnt_q;

  // While full every slice is dropped, so the accumulator never runs ahead.
  assign accept_wr = wr_en && !full_q;
  assign accept_rd = rd_en && !empty_q;

  hrav_slice_packer #(
    .DINWIDTH  (DINWIDTH),
    .DOUTWIDTH (DOUTWIDTH)
  ) u_packer (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (accept_wr),
    .din      (din),
    .din_last (din_last),
    .commit_c (commit),
    .word_c   (commit_word),
    .cnt_c    (commit_cnt)
  );

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (commit)    wr_ptr_d = wr_ptr_q + DEPTH'(1);
    if (accept_rd) rd_ptr_d = rd_ptr_q + DEPTH'(1);
    unique case ({commit, accept_rd})
      2'b10:   occ_d = occ_q + OCCW'(1);
      2'b01:   occ_d = occ_q - OCCW'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Control state, flags and read register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      dout_q     <= '0;
      dout_cnt_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      full_q   <= (occ_d == OCCW'(ENTRIES));
      empty_q  <= (occ_d == '0);
      if (accept_rd) begin
        dout_q     <= data_mem[rd_ptr_q];
        dout_cnt_q <= cnt_mem[rd_ptr_q];
      end
    end
  end

  // Word storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (commit) begin
      data_mem[wr_ptr_q] <= commit_word;
      cnt_mem[wr_ptr_q]  <= commit_cnt;
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign dout     = dout_q;
  assign dout_cnt = dout_cnt_q;

endmodule

// File: tb/tb_hrav_pack_fifo.sv
// Directed bench for hrav_pack_fifo: an 8->32 depth-4 instance driven from a
// vector table, plus an 8->256 default-parameter instance.
module tb_hrav_pack_fifo;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic        wr_en, din_last, rd_en;
  logic [7:0]  din;
  logic        full, empty;
  logic [31:0] dout;
  logic [2:0]  dout_cnt;

  logic         wr2, rd2;
  logic [7:0]   din2;
  logic         last2;
  logic         full2, empty2;
  logic [255:0] dout2;
  logic [5:0]   cnt2;

  always #5 clk = ~clk;

  hrav_pack_fifo #(.DINWIDTH(8), .DOUTWIDTH(32), .DEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .din(din), .din_last(din_last),
    .full(full), .rd_en(rd_en), .dout(dout), .dout_cnt(dout_cnt), .empty(empty)
  );

  hrav_pack_fifo dut_wide (
    .clk(clk), .reset_n(reset_n), .wr_en(wr2), .din(din2), .din_last(last2),
    .full(full2), .rd_en(rd2), .dout(dout2), .dout_cnt(cnt2), .empty(empty2)
  );

  typedef struct {
    logic        wr;
    logic [7:0]  din;
    logic        last;
    logic        rd;
    logic        e_full;
    logic        e_empty;
    logic [31:0] e_dout;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t        vq[$];
  logic [31:0] m_dout;
  logic [2:0]  m_cnt;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Append one cycle of stimulus; expected dout/cnt come from m_dout/m_cnt.
  task automatic av(input logic wr, input logic [7:0] d, input logic last,
                    input logic rd, input logic e_full, input logic e_empty);
    vec_t v;
    v.wr = wr; v.din = d; v.last = last; v.rd = rd;
    v.e_full = e_full; v.e_empty = e_empty; v.e_dout = m_dout; v.e_cnt = m_cnt;
    vq.push_back(v);
  endtask

  task automatic run_vecs(input string tag);
    foreach (vq[i]) begin
      @(negedge clk);
      wr_en = vq[i].wr; din = vq[i].din; din_last = vq[i].last; rd_en = vq[i].rd;
      @(posedge clk);
      #1;
      check($sformatf("%s_v%0d {full,empty,dout,cnt}", tag, i),
            64'({full, empty, dout, dout_cnt}),
            64'({vq[i].e_full, vq[i].e_empty, vq[i].e_dout, vq[i].e_cnt}));
    end
    @(negedge clk);
    wr_en = 1'b0; din_last = 1'b0; rd_en = 1'b0; din = '0;
    vq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    wr_en = 0; din = 0; din_last = 0; rd_en = 0;
    wr2 = 0; din2 = 0; last2 = 0; rd2 = 0;
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 64'({full, empty, dout, dout_cnt}), 64'({1'b0, 1'b1, 32'h0, 3'd0}));
    check("reset_wide_flags", 64'({full2, empty2, cnt2}), 64'({1'b0, 1'b1, 6'd0}));
    check("reset_wide_dout_lo", 64'(dout2[63:0]), 64'h0);
    @(negedge clk);
    reset_n = 1;

    m_dout = '0; m_cnt = '0;

    // Full word, read one cycle after empty falls.
    av(1, 8'h11, 0, 0, 0, 1); av(1, 8'h22, 0, 0, 0, 1);
    av(1, 8'h33, 0, 0, 0, 1); av(1, 8'h44, 0, 0, 0, 0);
    m_dout = 32'h44332211; m_cnt = 3'd4;
    av(0, 8'h00, 0, 1, 0, 1);
    av(0, 8'h00, 0, 0, 0, 1);

    // Partial word via din_last, then a fresh full word from slice 0.
    av(1, 8'hAA, 0, 0, 0, 1); av(1, 8'hBB, 1, 0, 0, 0);
    m_dout = 32'h0000BBAA; m_cnt = 3'd2;
    av(0, 8'h00, 0, 1, 0, 1);
    av(1, 8'h01, 0, 0, 0, 1); av(1, 8'h02, 0, 0, 0, 1);
    av(1, 8'h03, 0, 0, 0, 1); av(1, 8'h04, 0, 0, 0, 0);
    m_dout = 32'h04030201; m_cnt = 3'd4;
    av(0, 8'h00, 0, 1, 0, 1);
    // din_last on the very first slice: count 1.
    av(1, 8'hCC, 1, 0, 0, 0);
    m_dout = 32'h000000CC; m_cnt = 3'd1;
    av(0, 8'h00, 0, 1, 0, 1);
    run_vecs("basic");

    // Fill to full, drop writes while full, read+write while full, refill, drain.
    for (int w = 1; w <= 4; w++)
      for (int s = 0; s < 4; s++)
        av(1, 8'(w * 16 + s), 0, 0, (w == 4 && s == 3), (w == 1 && s < 3));
    av(1, 8'hEE, 0, 0, 1, 0);
    m_dout = 32'h13121110; m_cnt = 3'd4;
    av(1, 8'hEE, 0, 1, 0, 0);
    for (int s = 0; s < 4; s++) av(1, 8'(8'h50 + s), 0, 0, (s == 3), 0);
    m_dout = 32'h23222120; av(0, 8'h00, 0, 1, 0, 0);
    m_dout = 32'h33323130; av(0, 8'h00, 0, 1, 0, 0);
    m_dout = 32'h43424140; av(0, 8'h00, 0, 1, 0, 0);
    m_dout = 32'h53525150; av(0, 8'h00, 0, 1, 0, 1);
    run_vecs("fill");

    // Steady state: commit and read together at occupancy 2.
    for (int s = 0; s < 4; s++) av(1, 8'(8'h60 + s), 0, 0, 0, (s < 3));
    for (int s = 0; s < 4; s++) av(1, 8'(8'h70 + s), 0, 0, 0, 0);
    for (int s = 0; s < 3; s++) av(1, 8'(8'h80 + s), 0, 0, 0, 0);
    m_dout = 32'h63626160;
    av(1, 8'h83, 0, 1, 0, 0);
    m_dout = 32'h73727170; av(0, 8'h00, 0, 1, 0, 0);
    m_dout = 32'h83828180; av(0, 8'h00, 0, 1, 0, 1);
    // Read while empty leaves dout untouched; then a partial word in flight.
    av(0, 8'h00, 0, 1, 0, 1);
    av(1, 8'h91, 0, 0, 0, 1); av(1, 8'h92, 0, 0, 0, 1);
    run_vecs("steady");

    // Mid-word reset: asynchronous clear, partial word discarded.
    @(negedge clk);
    reset_n = 0;
    #1;
    check("midreset_async", 64'({full, empty, dout, dout_cnt}), 64'({1'b0, 1'b1, 32'h0, 3'd0}));
    @(negedge clk);
    reset_n = 1;
    m_dout = '0; m_cnt = '0;
    av(1, 8'hA1, 0, 0, 0, 1); av(1, 8'hA2, 0, 0, 0, 1);
    av(1, 8'hA3, 0, 0, 0, 1); av(1, 8'hA4, 0, 0, 0, 0);
    m_dout = 32'hA4A3A2A1; m_cnt = 3'd4;
    av(0, 8'h00, 0, 1, 0, 1);
    run_vecs("postreset");

    // Default parameters: 32 slices 0..31 form one 256-bit word.
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      wr2 = 1; din2 = 8'(i);
    end
    @(negedge clk);
    wr2 = 0;
    check("wide_not_empty", 64'({full2, empty2}), 64'({1'b0, 1'b0}));
    rd2 = 1;
    @(negedge clk);
    rd2 = 0;
    check("wide_cnt", 64'(cnt2), 64'd32);
    check("wide_empty_after", 64'(empty2), 64'd1);
    for (int k = 0; k < 32; k++)
      check($sformatf("wide_slice%0d", k), 64'(dout2[k*8 +: 8]), 64'(k));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
